// File: rtl/reg_writeback.sv
// reg_writeback: writeback stage in front of the 16x8 register file.
// Merges single-cycle ALU results and fixed-latency load returns into the
// register file's single write port. Tracks one in-flight load, buffers one
// colliding ALU result in a skid entry, and raises stall on load-use hazards
// or a full skid.
// Optional build macro: RWB_BLANK_R0_EN -- writes to register 0 are dropped
// (source still consumed, write_en stays low that cycle).
module reg_writeback #(
  parameter int W        = 8,
  parameter int D        = 4,
  parameter int LOAD_LAT = 2
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         alu_valid,
  input  logic [D-1:0] alu_waddr,
  input  logic [W-1:0] alu_data,
  input  logic         ld_issue,
  input  logic [D-1:0] ld_waddr,
  input  logic [W-1:0] mem_rdata,
  input  logic [D-1:0] raddrA,
  input  logic [D-1:0] raddrB,
  output logic         write_en,
  output logic [D-1:0] waddr,
  output logic [W-1:0] data_in,
  output logic         ld_busy,
  output logic         stall,
  output logic         ld_err
);

  localparam int CW = $clog2(LOAD_LAT + 1);

  typedef enum logic {L_IDLE, L_WAIT} ld_state_t;

  ld_state_t      state;
  logic [CW-1:0]  cnt;
  logic [D-1:0]   ld_dst;

  logic           skid_full;
  logic [D-1:0]   skid_waddr;
  logic [W-1:0]   skid_data;

  logic           ld_done;
  logic           alu_take;
  logic           src_valid;
  logic [D-1:0]   src_waddr;
  logic [W-1:0]   src_data;
  logic           skid_push;
  logic           wr_fire;

  assign ld_busy  = (state == L_WAIT);
  assign ld_done  = ld_busy && (cnt == CW'(1));
  // Hazard compares the latched destination of the in-flight load.
  assign stall    = skid_full | (ld_busy & ((ld_dst == raddrA) | (ld_dst == raddrB)));
  assign alu_take = alu_valid & ~stall;

  // Write-port arbitration: load completion, then skid entry, then fresh ALU result.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    src_valid = 1'b0;
    src_waddr = alu_waddr;
    src_data  = alu_data;
    skid_push = 1'b0;
    if (ld_done) begin
      src_valid = 1'b1;
      src_waddr = ld_dst;
      src_data  = mem_rdata;
      skid_push = alu_take;  // losing ALU result parks in the skid
    end else if (skid_full) begin
      src_valid = 1'b1;
      src_waddr = skid_waddr;
      src_data  = skid_data;
    end else if (alu_take) begin
      src_valid = 1'b1;
    end
  end

`ifdef RWB_BLANK_R0_EN
  assign wr_fire = src_valid && (src_waddr != '0);
`else
  assign wr_fire = src_valid;
`endif

  // Load tracker: counts LOAD_LAT edges from issue, retires on cnt==1.
  always_ff @(posedge CLK or posedge Reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (Reset) begin
      state  <= L_IDLE;
      cnt    <= '0;
      ld_dst <= '0;
    end else begin
      case (state)
        L_IDLE: begin
          if (ld_issue) begin
            state  <= L_WAIT;
            cnt    <= CW'(LOAD_LAT);
            ld_dst <= ld_waddr;
          end
        end
        L_WAIT: begin
          if (cnt == CW'(1)) begin
            // An issue on the completion edge starts the next load back to back.
            if (ld_issue) begin
              cnt    <= CW'(LOAD_LAT);
              ld_dst <= ld_waddr;
            end else begin
              state <= L_IDLE;
              cnt   <= '0;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
      endcase
    end
  end

  // Sticky error: a second load issued while one is still outstanding.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      ld_err <= 1'b0;
    end else if (ld_issue && ld_busy && !ld_done) begin
      ld_err <= 1'b1;
    end
  end

  // One-entry skid: fills when an ALU result loses to a load, drains on a load-free edge.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      skid_full  <= 1'b0;
      skid_waddr <= '0;
      skid_data  <= '0;
    end else if (skid_push) begin
      skid_full  <= 1'b1;
      skid_waddr <= alu_waddr;
      skid_data  <= alu_data;
    end else if (skid_full && !ld_done) begin
      skid_full <= 1'b0;
    end
  end

  // Registered write port; address and data hold when nothing is written.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      write_en <= 1'b0;
      waddr    <= '0;
      data_in  <= '0;
    end else begin
      write_en <= wr_fire;
      if (wr_fire) begin
        waddr   <= src_waddr;
        data_in <= src_data;
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: directed scenarios plus randomized traffic, checked
// against a queue-based model of the writeback port.
module tb_reg_writeback;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int LL = 2;

  logic         CLK = 1'b0;
  logic         Reset;
  logic         alu_valid;
  logic [D-1:0] alu_waddr;
  logic [W-1:0] alu_data;
  logic         ld_issue;
  logic [D-1:0] ld_waddr;
  logic [W-1:0] mem_rdata;
  logic [D-1:0] raddrA;
  logic [D-1:0] raddrB;
  logic         write_en;
  logic [D-1:0] waddr;
  logic [W-1:0] data_in;
  logic         ld_busy;
  logic         stall;
  logic         ld_err;

  reg_writeback #(.W(W), .D(D), .LOAD_LAT(LL)) dut (
    .CLK(CLK), .Reset(Reset),
    .alu_valid(alu_valid), .alu_waddr(alu_waddr), .alu_data(alu_data),
    .ld_issue(ld_issue), .ld_waddr(ld_waddr), .mem_rdata(mem_rdata),
    .raddrA(raddrA), .raddrB(raddrB),
    .write_en(write_en), .waddr(waddr), .data_in(data_in),
    .ld_busy(ld_busy), .stall(stall), .ld_err(ld_err)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: pending writes form an ordered queue (load first, then
  // older parked result, then new ALU result); the port retires the head each edge.
  typedef struct packed {
    logic [D-1:0] a;
    logic [W-1:0] d;
  } wr_t;

  bit           m_live;
  int           m_due;
  logic [D-1:0] m_dst;
  wr_t          m_pend[$];
  bit           m_err;
  logic         m_we;
  logic [D-1:0] m_waddr;
  logic [W-1:0] m_data;
  int           cyc = 0;

  task automatic model_reset();
    m_live  = 0;
    m_due   = 0;
    m_dst   = '0;
    m_pend  = {};
    m_err   = 0;
    m_we    = 0;
    m_waddr = '0;
    m_data  = '0;
  endtask

  task automatic drive_idle();
    alu_valid = 0; alu_waddr = '0; alu_data = '0;
    ld_issue  = 0; ld_waddr  = '0; mem_rdata = '0;
    raddrA    = '0; raddrB   = '0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    Reset = 1;
    drive_idle();
    #1;
    model_reset();
    check("rst_write_en", write_en, 0);
    check("rst_waddr", waddr, 0);
    check("rst_data_in", data_in, 0);
    check("rst_ld_busy", ld_busy, 0);
    check("rst_ld_err", ld_err, 0);
    check("rst_stall", stall, 0);
    @(negedge CLK);
    Reset = 0;
  endtask

  // One clock: drive inputs, check combinational outputs, advance model, check registered outputs.
  task automatic step(input logic av, input logic [D-1:0] aa, input logic [W-1:0] ad,
                      input logic li, input logic [D-1:0] la, input logic [W-1:0] md,
                      input logic [D-1:0] ra, input logic [D-1:0] rb, output bit accepted);
    bit  exp_stall;
    bit  done;
    wr_t q[$];
    @(negedge CLK);
    alu_valid = av; alu_waddr = aa; alu_data = ad;
    ld_issue  = li; ld_waddr  = la; mem_rdata = md;
    raddrA    = ra; raddrB    = rb;
    #1;
    exp_stall = (m_pend.size() != 0) || (m_live && (m_dst == ra || m_dst == rb));
    check("stall", stall, exp_stall);
    check("ld_busy", ld_busy, m_live);

    done = m_live && (cyc == m_due);
    q = {};
    if (done) q.push_back('{a: m_dst, d: md});
    foreach (m_pend[i]) q.push_back(m_pend[i]);
    accepted = av && !exp_stall;
    if (accepted) q.push_back('{a: aa, d: ad});
    m_pend = {};
    for (int i = 1; i < q.size(); i++) m_pend.push_back(q[i]);
    m_we = 0;
    if (q.size() > 0) begin
`ifdef RWB_BLANK_R0_EN
      if (q[0].a != '0) begin
        m_we = 1; m_waddr = q[0].a; m_data = q[0].d;
      end
`else
      m_we = 1; m_waddr = q[0].a; m_data = q[0].d;
`endif
    end
    if (li) begin
      if (!m_live || done) begin
        m_live = 1; m_due = cyc + LL; m_dst = la;
      end else begin
        m_err = 1;
      end
    end else if (done) begin
      m_live = 0;
    end
    cyc++;

    @(posedge CLK);
    #1;
    check("write_en", write_en, m_we);
    check("waddr", waddr, m_waddr);
    check("data_in", data_in, m_data);
    check("ld_err", ld_err, m_err);
  endtask

  logic         hold_v;
  logic         r_av;
  logic [D-1:0] r_aa;
  logic [W-1:0] r_ad;
  bit           acc;

  initial begin
    Reset = 1;
    drive_idle();
    model_reset();
    do_reset();

    // Reset mid-load: load r3, reset next cycle, late data never written.
    step(0, 0, 0, 1, 3, 0, 0, 0, acc);
    do_reset();
    step(0, 0, 0, 0, 0, 8'h55, 0, 0, acc);
    check("t1_write_en", write_en, 0);
    check("t1_ld_busy", ld_busy, 0);

    // ALU write r5=A7, then idle.
    step(1, 5, 8'hA7, 0, 0, 0, 0, 0, acc);
    check("t2_write_en", write_en, 1);
    check("t2_waddr", waddr, 5);
    check("t2_data_in", data_in, 8'hA7);
    step(0, 0, 0, 0, 0, 0, 0, 0, acc);
    check("t2_write_en_off", write_en, 0);

    // Load r2, data 3C returns on the second edge after issue.
    step(0, 0, 0, 1, 2, 0, 0, 0, acc);
    check("t3_busy0", ld_busy, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, acc);
    check("t3_busy1", ld_busy, 1);
    step(0, 0, 0, 0, 0, 8'h3C, 0, 0, acc);
    check("t3_write_en", write_en, 1);
    check("t3_waddr", waddr, 2);
    check("t3_data_in", data_in, 8'h3C);
    check("t3_busy_done", ld_busy, 0);

    // Collision: load r2=11 completes with ALU r7=22 -> r2 first, r7 next.
    step(0, 0, 0, 1, 2, 0, 0, 0, acc);
    step(0, 0, 0, 0, 0, 0, 0, 0, acc);
    step(1, 7, 8'h22, 0, 0, 8'h11, 0, 0, acc);
    check("t4_waddr_ld", waddr, 2);
    check("t4_data_ld", data_in, 8'h11);
    check("t4_stall", stall, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, acc);
    check("t4_waddr_alu", waddr, 7);
    check("t4_data_alu", data_in, 8'h22);
    check("t4_stall_clear", stall, 0);

    // Load-use on r4 via raddrB; second issue during the window sets ld_err.
    step(0, 0, 0, 1, 4, 0, 0, 0, acc);
    step(0, 0, 0, 1, 9, 0, 0, 4, acc);
    check("t5_ld_err", ld_err, 1);
    step(0, 0, 0, 0, 0, 8'h66, 0, 4, acc);
    check("t5_data", data_in, 8'h66);
    step(0, 0, 0, 0, 0, 0, 0, 0, acc);
    check("t5_ld_err_sticky", ld_err, 1);

    // Register 0 write.
    do_reset();
    step(1, 0, 8'hFF, 0, 0, 0, 0, 0, acc);
`ifdef RWB_BLANK_R0_EN
    check("t6_write_en", write_en, 0);
`else
    check("t6_write_en", write_en, 1);
    check("t6_waddr", waddr, 0);
`endif

    // Randomized traffic; a stalled ALU result is held by upstream.
    hold_v = 0;
    r_av = 0; r_aa = '0; r_ad = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
        hold_v = 0;
      end
      if (!hold_v) begin
        r_av = 1'($urandom_range(0, 1));
        r_aa = D'($urandom);
        r_ad = W'($urandom);
      end
      step(r_av, r_aa, r_ad, ($urandom_range(0, 3) == 0), D'($urandom), W'($urandom),
           D'($urandom), D'($urandom), acc);
      hold_v = r_av && !acc;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
